// File: rtl/ahb_copy_master.sv
// AHB-Lite initiator copying len 32-bit words from src to dst, one NONSEQ single transfer per phase.
// Optional AHB_COPY_FIXED_SRC_EN adds cmd_src_fixed to keep src constant (peripheral data register reads).
module ahb_copy_master #(
   parameter int unsigned LEN_WIDTH = 16,
   parameter logic [3:0]  HPROT_VAL = 4'b0011
) (
   input  logic                 HCLK,
   input  logic                 HRESETn,
   // Command handshake: a command transfers on a rising HCLK edge where cmd_valid && cmd_ready.
   input  logic                 cmd_valid,
   output logic                 cmd_ready,
   input  logic [31:0]          cmd_src,
   input  logic [31:0]          cmd_dst,
   input  logic [LEN_WIDTH-1:0] cmd_len,
`ifdef AHB_COPY_FIXED_SRC_EN
   input  logic                 cmd_src_fixed,
`endif
   output logic                 busy,
   output logic                 done,
   output logic                 err,
   output logic [31:0]          HADDR,
   output logic [1:0]           HTRANS,
   output logic                 HWRITE,
   output logic [2:0]           HSIZE,
   output logic [2:0]           HBURST,
   output logic [3:0]           HPROT,
   output logic                 HMASTLOCK,
   output logic [31:0]          HWDATA,
   input  logic [31:0]          HRDATA,
   input  logic                 HREADY,
   input  logic                 HRESP,
   output logic [2:0]           dbg_state
);

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_RD_A = 3'd1,
      ST_RD_D = 3'd2,
      ST_WR_A = 3'd3,
      ST_WR_D = 3'd4,
      ST_FIN  = 3'd5
   } state_t;

   localparam logic [1:0] TR_IDLE   = 2'b00;
   localparam logic [1:0] TR_NONSEQ = 2'b10;

   state_t                state_q, state_d;
   logic [31:0]           src_q, src_d, dst_q, dst_d, buf_q, buf_d;
   logic [LEN_WIDTH-1:0]  len_q, len_d;
   logic                  busy_q, busy_d, done_q, done_d, err_q, err_d, ready_q, ready_d;
   logic [1:0]            htrans_q, htrans_d;
   logic [31:0]           haddr_q, haddr_d, hwdata_q, hwdata_d;
   logic                  hwrite_q, hwrite_d;
   logic [31:0]           src_next;

`ifdef AHB_COPY_FIXED_SRC_EN
   logic fixed_q, fixed_d;
   assign src_next = fixed_q ? src_q : src_q + 32'd4;
`else
   assign src_next = src_q + 32'd4;
`endif

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         state_q  <= ST_IDLE;
         src_q    <= '0;
         dst_q    <= '0;
         len_q    <= '0;
         buf_q    <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         err_q    <= 1'b0;
         ready_q  <= 1'b1;
         htrans_q <= TR_IDLE;
         haddr_q  <= '0;
         hwrite_q <= 1'b0;
         hwdata_q <= '0;
`ifdef AHB_COPY_FIXED_SRC_EN
         fixed_q  <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         src_q    <= src_d;
         dst_q    <= dst_d;
         len_q    <= len_d;
         buf_q    <= buf_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         err_q    <= err_d;
         ready_q  <= ready_d;
         htrans_q <= htrans_d;
         haddr_q  <= haddr_d;
         hwrite_q <= hwrite_d;
         hwdata_q <= hwdata_d;
`ifdef AHB_COPY_FIXED_SRC_EN
         fixed_q  <= fixed_d;
`endif
      end
   end

   always_comb begin
      state_d  = state_q;
      src_d    = src_q;
      dst_d    = dst_q;
      len_d    = len_q;
      buf_d    = buf_q;
      busy_d   = busy_q;
      done_d   = 1'b0;
      err_d    = 1'b0;
      htrans_d = htrans_q;
      haddr_d  = haddr_q;
      hwrite_d = hwrite_q;
      hwdata_d = hwdata_q;
`ifdef AHB_COPY_FIXED_SRC_EN
      fixed_d  = fixed_q;
`endif
      case (state_q)
         ST_IDLE: begin
            // busy in IDLE means a command was latched on the previous edge and awaits dispatch
            if (busy_q) begin
               if ((src_q[1:0] != 2'b00) || (dst_q[1:0] != 2'b00)) begin
                  err_d  = 1'b1;
                  busy_d = 1'b0;
               end else if (len_q == '0) begin
                  state_d = ST_FIN;
               end else begin
                  state_d  = ST_RD_A;
                  htrans_d = TR_NONSEQ;
                  haddr_d  = src_q;
                  hwrite_d = 1'b0;
               end
            end else if (cmd_valid) begin
               src_d  = cmd_src;
               dst_d  = cmd_dst;
               len_d  = cmd_len;
               busy_d = 1'b1;
`ifdef AHB_COPY_FIXED_SRC_EN
               fixed_d = cmd_src_fixed;
`endif
            end
         end
         ST_RD_A: begin
            if (HREADY) begin
               state_d  = ST_RD_D;
               htrans_d = TR_IDLE;
            end
         end
         ST_RD_D: begin
            if (HREADY) begin
               if (HRESP) begin
                  state_d = ST_IDLE;
                  err_d   = 1'b1;
                  busy_d  = 1'b0;
               end else begin
                  buf_d    = HRDATA;
                  state_d  = ST_WR_A;
                  htrans_d = TR_NONSEQ;
                  haddr_d  = dst_q;
                  hwrite_d = 1'b1;
               end
            end
         end
         ST_WR_A: begin
            if (HREADY) begin
               state_d  = ST_WR_D;
               htrans_d = TR_IDLE;
               hwdata_d = buf_q;
            end
         end
         ST_WR_D: begin
            if (HREADY) begin
               if (HRESP) begin
                  state_d = ST_IDLE;
                  err_d   = 1'b1;
                  busy_d  = 1'b0;
               end else begin
                  src_d = src_next;
                  dst_d = dst_q + 32'd4;
                  if (len_q != '0) len_d = len_q - LEN_WIDTH'(1);
                  if (len_q <= LEN_WIDTH'(1)) begin
                     state_d = ST_FIN;
                  end else begin
                     state_d  = ST_RD_A;
                     htrans_d = TR_NONSEQ;
                     haddr_d  = src_next;
                     hwrite_d = 1'b0;
                  end
               end
            end
         end
         ST_FIN: begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
            busy_d  = 1'b0;
         end
         default: state_d = ST_IDLE;
      endcase
      ready_d = ~busy_d;
   end

   assign cmd_ready = ready_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign err       = err_q;
   assign HADDR     = haddr_q;
   assign HTRANS    = htrans_q;
   assign HWRITE    = hwrite_q;
   assign HWDATA    = hwdata_q;
   assign HSIZE     = 3'b010;
   assign HBURST    = 3'b000;
   assign HPROT     = HPROT_VAL;
   assign HMASTLOCK = 1'b0;
   assign dbg_state = state_q;

endmodule

// File: tb/tb_ahb_copy_master.sv
// Directed bench for ahb_copy_master with a memory responder (wait states, two-cycle ERROR).
// Build with +define+AHB_COPY_FIXED_SRC_EN to also cover the fixed-source copy.
module tb_ahb_copy_master;

   logic        HCLK = 1'b0;
   logic        HRESETn;
   logic        cmd_valid, cmd_ready;
   logic [31:0] cmd_src, cmd_dst;
   logic [15:0] cmd_len;
`ifdef AHB_COPY_FIXED_SRC_EN
   logic        cmd_src_fixed;
`endif
   logic        busy, done, err;
   logic [31:0] HADDR, HWDATA, HRDATA;
   logic [1:0]  HTRANS;
   logic        HWRITE, HMASTLOCK, HREADY, HRESP;
   logic [2:0]  HSIZE, HBURST, dbg_state;
   logic [3:0]  HPROT;

   always #5 HCLK = ~HCLK;

   ahb_copy_master dut (
      .HCLK(HCLK), .HRESETn(HRESETn),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_src(cmd_src), .cmd_dst(cmd_dst), .cmd_len(cmd_len),
`ifdef AHB_COPY_FIXED_SRC_EN
      .cmd_src_fixed(cmd_src_fixed),
`endif
      .busy(busy), .done(done), .err(err),
      .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE),
      .HBURST(HBURST), .HPROT(HPROT), .HMASTLOCK(HMASTLOCK), .HWDATA(HWDATA),
      .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP),
      .dbg_state(dbg_state)
   );

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, act, exp);
   endtask

   // ---------------- responder ----------------
   logic [31:0] mem [logic [31:0]];
   logic [31:0] log_addr[$];
   logic        log_wr[$];
   int          ws_cfg, err_read_n;
   int          read_cnt, viol_cnt;
   logic        dp_active, dp_write, dp_err, dp_first, dp_errph;
   logic [31:0] dp_addr, dp_wdata;
   int          dp_wait;
   logic        rsp_rdy, rsp_err;

   function automatic logic [31:0] src_pattern(input logic [31:0] a);
      if (a >= 32'h2000_0000 && a < 32'h2000_0100) return 32'hA1 + ((a - 32'h2000_0000) >> 2);
      return 32'h5000_0000 ^ a;
   endfunction

   always @(negedge HCLK) begin
      if (!HRESETn) begin
         dp_active = 1'b0;
         HREADY    = 1'b1;
         HRESP     = 1'b0;
         HRDATA    = '0;
      end else begin
         rsp_rdy = 1'b1;
         rsp_err = 1'b0;
         if (cmd_valid && cmd_ready) begin
            log_addr.delete();
            log_wr.delete();
            read_cnt = 0;
            viol_cnt = 0;
         end
         if (dp_active) begin
            if (HADDR !== dp_addr) viol_cnt++;
            if (dp_write) begin
               if (dp_first) dp_wdata = HWDATA;
               else if (HWDATA !== dp_wdata) viol_cnt++;
            end
            dp_first = 1'b0;
            if (dp_wait > 0) begin
               rsp_rdy = 1'b0;
               dp_wait--;
            end else if (dp_err) begin
               rsp_err = 1'b1;
               if (!dp_errph) begin
                  rsp_rdy  = 1'b0;
                  dp_errph = 1'b1;
               end else begin
                  dp_active = 1'b0;
               end
            end else begin
               if (dp_write) mem[dp_addr] = HWDATA;
               else HRDATA = mem.exists(dp_addr) ? mem[dp_addr] : src_pattern(dp_addr);
               dp_active = 1'b0;
            end
         end
         if (rsp_rdy && HTRANS == 2'b10) begin
            dp_active = 1'b1;
            dp_addr   = HADDR;
            dp_write  = HWRITE;
            dp_wait   = ws_cfg;
            dp_first  = 1'b1;
            dp_errph  = 1'b0;
            dp_err    = 1'b0;
            log_addr.push_back(HADDR);
            log_wr.push_back(HWRITE);
            if (!HWRITE) begin
               read_cnt++;
               dp_err = (read_cnt == err_read_n);
            end
         end
         HREADY = rsp_rdy;
         HRESP  = rsp_err;
      end
   end

   function automatic logic [31:0] dst_rd(input logic [31:0] a);
      return mem.exists(a) ? mem[a] : 32'hDEAD_BEEF;
   endfunction

   // ---------------- driver ----------------
   int   r_done_edge, r_err_edge, r_done_cnt, r_err_cnt;
   logic r_busy_acc, r_ready_acc, r_ready_pre, r_busy_pulse, r_ready_pulse;
   logic [31:0] exp_q[$];

   task automatic run_cmd(input logic [31:0] s, input logic [31:0] d, input logic [15:0] l);
      int stop_at;
      @(posedge HCLK); #1;
      r_ready_pre = cmd_ready;
      cmd_src = s; cmd_dst = d; cmd_len = l; cmd_valid = 1'b1;
      @(posedge HCLK); #1;
      cmd_valid   = 1'b0;
      r_busy_acc  = busy;
      r_ready_acc = cmd_ready;
      r_done_edge = -1; r_err_edge = -1; r_done_cnt = 0; r_err_cnt = 0;
      r_busy_pulse = 1'b1; r_ready_pulse = 1'b0;
      stop_at = 300;
      for (int k = 1; k <= stop_at; k++) begin
         @(posedge HCLK); #1;
         if (done) begin
            r_done_cnt++;
            if (r_done_edge < 0) r_done_edge = k;
         end
         if (err) begin
            r_err_cnt++;
            if (r_err_edge < 0) r_err_edge = k;
         end
         if ((done || err) && stop_at == 300) begin
            stop_at = k + 2;
            r_busy_pulse  = busy;
            r_ready_pulse = cmd_ready;
         end
      end
   endtask

   task automatic check_dst(input string tag, input logic [31:0] d);
      int i;
      i = 0;
      while (exp_q.size() > 0) begin
         check_eq($sformatf("%s_data%0d", tag, i), dst_rd(d + 32'(4 * i)), exp_q.pop_front());
         i++;
      end
   endtask

   task automatic check_log(input string tag, input logic [31:0] s, input logic [31:0] d, input int n, input logic s_fixed);
      check_eq({tag, "_ntransfers"}, log_addr.size(), n);
      for (int i = 0; i < log_addr.size() && i < n; i++) begin
         check_eq($sformatf("%s_hwrite%0d", tag, i), {31'b0, log_wr[i]}, (i % 2 == 1) ? 1 : 0);
         if (i % 2 == 1) check_eq($sformatf("%s_haddr%0d", tag, i), log_addr[i], d + 32'(4 * (i / 2)));
         else check_eq($sformatf("%s_haddr%0d", tag, i), log_addr[i], s_fixed ? s : s + 32'(4 * (i / 2)));
      end
   endtask

   initial begin
      HRESETn = 1'b0;
      cmd_valid = 1'b0; cmd_src = '0; cmd_dst = '0; cmd_len = '0;
`ifdef AHB_COPY_FIXED_SRC_EN
      cmd_src_fixed = 1'b0;
`endif
      ws_cfg = 0; err_read_n = 0;
      repeat (3) @(posedge HCLK);
      #1;
      check_eq("rst_htrans", {30'b0, HTRANS}, 0);
      check_eq("rst_haddr", HADDR, 0);
      check_eq("rst_hwrite", {31'b0, HWRITE}, 0);
      check_eq("rst_hwdata", HWDATA, 0);
      check_eq("rst_busy", {31'b0, busy}, 0);
      check_eq("rst_done", {31'b0, done}, 0);
      check_eq("rst_err", {31'b0, err}, 0);
      check_eq("rst_cmd_ready", {31'b0, cmd_ready}, 1);
      check_eq("rst_state", {29'b0, dbg_state}, 0);
      check_eq("fix_hsize", {29'b0, HSIZE}, 3'b010);
      check_eq("fix_hburst", {29'b0, HBURST}, 0);
      check_eq("fix_hprot", {28'b0, HPROT}, 4'b0011);
      check_eq("fix_hmastlock", {31'b0, HMASTLOCK}, 0);
      HRESETn = 1'b1;

      // basic copy, zero wait states
      run_cmd(32'h2000_0000, 32'h2000_0100, 16'd3);
      check_eq("basic_ready_pre", {31'b0, r_ready_pre}, 1);
      check_eq("basic_busy_acc", {31'b0, r_busy_acc}, 1);
      check_eq("basic_ready_acc", {31'b0, r_ready_acc}, 0);
      check_eq("basic_done_edge", r_done_edge, 14);
      check_eq("basic_done_cnt", r_done_cnt, 1);
      check_eq("basic_err_cnt", r_err_cnt, 0);
      check_eq("basic_busy_at_done", {31'b0, r_busy_pulse}, 0);
      check_eq("basic_ready_at_done", {31'b0, r_ready_pulse}, 1);
      check_log("basic", 32'h2000_0000, 32'h2000_0100, 6, 1'b0);
      exp_q.push_back(32'hA1); exp_q.push_back(32'hA2); exp_q.push_back(32'hA3);
      check_dst("basic", 32'h2000_0100);

      // two wait states on every data phase
      ws_cfg = 2;
      run_cmd(32'h2000_0010, 32'h2000_0200, 16'd2);
      ws_cfg = 0;
      check_eq("wait_done_edge", r_done_edge, 18);
      check_eq("wait_err_cnt", r_err_cnt, 0);
      check_eq("wait_stability_viol", viol_cnt, 0);
      check_log("wait", 32'h2000_0010, 32'h2000_0200, 4, 1'b0);
      exp_q.push_back(32'hA5); exp_q.push_back(32'hA6);
      check_dst("wait", 32'h2000_0200);

      // ERROR on the second read
      err_read_n = 2;
      run_cmd(32'h2000_0020, 32'h2000_0300, 16'd4);
      err_read_n = 0;
      check_eq("rderr_err_edge", r_err_edge, 8);
      check_eq("rderr_err_cnt", r_err_cnt, 1);
      check_eq("rderr_done_cnt", r_done_cnt, 0);
      check_eq("rderr_busy_at_err", {31'b0, r_busy_pulse}, 0);
      check_log("rderr", 32'h2000_0020, 32'h2000_0300, 3, 1'b0);
      exp_q.push_back(32'hA9);
      check_dst("rderr", 32'h2000_0300);

      // zero-length command
      run_cmd(32'h2000_0000, 32'h2000_0700, 16'd0);
      check_eq("len0_done_edge", r_done_edge, 2);
      check_eq("len0_err_cnt", r_err_cnt, 0);
      check_eq("len0_ntransfers", log_addr.size(), 0);

      // misaligned destination
      run_cmd(32'h2000_0000, 32'h2000_0002, 16'd2);
      check_eq("misal_err_edge", r_err_edge, 1);
      check_eq("misal_done_cnt", r_done_cnt, 0);
      check_eq("misal_ntransfers", log_addr.size(), 0);
      check_eq("misal_ready_after", {31'b0, r_ready_pulse}, 1);

      // reset while in the write data phase
      @(posedge HCLK); #1;
      cmd_src = 32'h2000_0000; cmd_dst = 32'h2000_0500; cmd_len = 16'd2; cmd_valid = 1'b1;
      @(posedge HCLK); #1;
      cmd_valid = 1'b0;
      repeat (4) @(posedge HCLK);
      #1;
      check_eq("rmid_pre_state", {29'b0, dbg_state}, 3'd4);
      check_eq("rmid_pre_hwrite", {31'b0, HWRITE}, 1);
      check_eq("rmid_pre_hwdata", HWDATA, 32'hA1);
      #2 HRESETn = 1'b0;
      #1;
      check_eq("rmid_htrans", {30'b0, HTRANS}, 0);
      check_eq("rmid_busy", {31'b0, busy}, 0);
      check_eq("rmid_hwrite", {31'b0, HWRITE}, 0);
      check_eq("rmid_haddr", HADDR, 0);
      check_eq("rmid_hwdata", HWDATA, 0);
      check_eq("rmid_done", {31'b0, done}, 0);
      check_eq("rmid_err", {31'b0, err}, 0);
      check_eq("rmid_state", {29'b0, dbg_state}, 0);
      repeat (2) @(posedge HCLK);
      #1 HRESETn = 1'b1;
      @(posedge HCLK); #1;
      check_eq("rmid_ready_after", {31'b0, cmd_ready}, 1);
      run_cmd(32'h2000_0030, 32'h2000_0400, 16'd1);
      check_eq("rmid_new_done_edge", r_done_edge, 6);
      check_eq("rmid_new_err_cnt", r_err_cnt, 0);
      exp_q.push_back(32'hAD);
      check_dst("rmid_new", 32'h2000_0400);

`ifdef AHB_COPY_FIXED_SRC_EN
      // fixed source: every read at the same address
      cmd_src_fixed = 1'b1;
      run_cmd(32'h4000_0010, 32'h2000_0600, 16'd3);
      cmd_src_fixed = 1'b0;
      check_eq("fixed_done_edge", r_done_edge, 14);
      check_eq("fixed_err_cnt", r_err_cnt, 0);
      check_log("fixed", 32'h4000_0010, 32'h2000_0600, 6, 1'b1);
      exp_q.push_back(32'h1000_0010); exp_q.push_back(32'h1000_0010); exp_q.push_back(32'h1000_0010);
      check_dst("fixed", 32'h2000_0600);
`endif

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/ahb_copy_master.md
# ahb_copy_master

- Single-channel AHB-Lite initiator that copies a block of 32-bit words from a source address to a destination address.
- Sits on a spare subordinate port of the AHB interconnect as a second master, beside the core. It is the initiator counterpart to the memory and peripheral responders.
- Intended use: moving NI-PCB ADC samples into SRAM without core involvement.
- Commands arrive on a valid/ready port; completion and bus errors are reported as single-cycle pulses.

## Interface
- `LEN_WIDTH`, 16: width of the word-count field.
- `HPROT_VAL`, 4'b0011: constant HPROT (data, privileged).
- `HCLK` in 1: sole clock.
- `HRESETn` in 1: asynchronous, active-low reset.
- `cmd_valid` in 1: command offered.
- `cmd_ready` out 1: high only in IDLE.
- `cmd_src` in 32: source byte address.
- `cmd_dst` in 32: destination byte address.
- `cmd_len` in LEN_WIDTH: number of words to copy.
- `busy` out 1: high from command acceptance until the done or error pulse.
- `done` out 1: one-cycle pulse on successful completion.
- `err` out 1: one-cycle pulse on bus error or a misaligned command.
- `HADDR` out 32, `HTRANS` out 2, `HWRITE` out 1, `HSIZE` out 3, `HBURST` out 3, `HPROT` out 4, `HMASTLOCK` out 1, `HWDATA` out 32: AHB-Lite master outputs.
- `HRDATA` in 32, `HREADY` in 1, `HRESP` in 1: AHB-Lite master inputs.

## Operation
- States: IDLE, RD_A, RD_D, WR_A, WR_D, FIN.
- **IDLE**
  - `cmd_ready`=1.
  - On `cmd_valid`: latch src, dst and len into registers, `busy`=1.
  - If src[1:0] or dst[1:0] ≠ 0: pulse `err` next cycle, no bus activity, stay in IDLE.
  - If len=0: go to FIN.
  - Otherwise go to RD_A.
- **RD_A**
  - Drive HTRANS=NONSEQ, HADDR=src, HWRITE=0.
  - Stay until HREADY=1, then go to RD_D.
- **RD_D**
  - HTRANS=IDLE.
  - Wait for HREADY=1. If HRESP=1 at that point, abort. Otherwise latch HRDATA into a 32-bit buffer and go to WR_A.
- **WR_A**
  - Drive HTRANS=NONSEQ, HADDR=dst, HWRITE=1.
  - On HREADY=1, go to WR_D.
- **WR_D**
  - HTRANS=IDLE, HWDATA=buffer (held stable for the whole data phase).
  - On HREADY=1 with HRESP=1: abort.
  - On HREADY=1 with HRESP=0: src+=4, dst+=4, len−=1. If the new len is 0, go to FIN; otherwise go to RD_A.
- **FIN**: pulse `done`, drop `busy`, return to IDLE.
- **Abort**: pulse `err`, drop `busy`, return to IDLE.
  - The remaining count is discarded.
  - The first (HREADY=0, HRESP=1) cycle of an ERROR response needs no action, because HTRANS is already IDLE.
- **Arithmetic**
  - Address increments wrap modulo 2^32.
  - len is unsigned and never decrements below 0.
- **Fixed bus fields**: HSIZE=3'b010, HBURST=3'b000, HMASTLOCK=0, HPROT=`HPROT_VAL`.
- **Command port**: `cmd_valid` outside IDLE is ignored, with no queueing.

## Timing
- Reset values:
  - HTRANS=0, HADDR=0, HWRITE=0, HWDATA=0.
  - `busy`=0, `done`=0, `err`=0.
  - `cmd_ready`=1.
  - State=IDLE.
- All outputs are registered.
- Command accepted at edge N: HTRANS=NONSEQ is visible after edge N+1.
- Zero-wait-state timing: 4 cycles per word. N words: `done` pulse after edge 4N+2 from acceptance.
- Wait states extend the current phase only; outputs hold while HREADY=0.
- Reset asserted mid-transfer: all outputs return to reset values immediately (asynchronous) and no pulse is emitted. The partially copied block is left as is.

## Configuration
- `AHB_COPY_FIXED_SRC_EN` defined:
  - Adds input `cmd_src_fixed` (1 bit), latched with the command.
  - When latched high, src is not incremented; every read hits the same address, e.g. a peripheral data register.
- Undefined: the port is absent and src always increments.

## Test plan
- **Basic copy**: src=0x2000_0000, dst=0x2000_0100, len=3, zero-wait responder holding 0xA1,0xA2,0xA3 → the dst words read back as 0xA1,0xA2,0xA3, 6 NONSEQ transfers alternating read/write, `done` after edge 14, `err`=0.
- **Wait states**: responder inserts 2 wait states on every data phase, len=2 → data is correct, HADDR/HWDATA stable during waits, `done` after edge 18.
- **Read error**: HRESP=1 on the second read, len=4 → exactly one write was issued, `err` pulses, `done` never pulses, `busy` drops.
- **Degenerate commands**: len=0 → `done` one cycle later with no NONSEQ. dst=0x2000_0002 → `err` with no bus activity.
- **Reset mid-copy**: HRESETn pulled low during WR_D → HTRANS=0 and `busy`=0 with no clock edge. After release, `cmd_ready`=1 and a new len=1 copy succeeds.
- **Fixed source**: with `AHB_COPY_FIXED_SRC_EN`, src=0x4000_0010, fixed=1, len=3 → all reads at 0x4000_0010, writes at dst, dst+4 and dst+8.
